// File: rtl/cust_hp_filter_mc.sv
// Multichannel first-order IIR high-pass filter with per-channel state in RAM.
// One sample in flight: IDLE -> RD -> CALC -> OUT, plus a CLEAR sweep of all states.
module cust_hp_filter_mc #(
    parameter int DATA_W  = 16,
    parameter int CHAN_W  = 8,
    parameter int N_CHAN  = 160,
    parameter int COEFF_W = 16,
    parameter int FRAC_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  chan_in_sample,
    input  logic [CHAN_W-1:0]  chan_in_num,
    input  logic               chan_in_valid,
    output logic               chan_in_read,
    output logic [DATA_W-1:0]  chan_out_sample,
    output logic [CHAN_W-1:0]  chan_out_num,
    output logic               chan_out_valid,
    input  logic               chan_out_read,
    input  logic [COEFF_W-1:0] coeff,
    input  logic               bypass,
    input  logic               clear_state,
    output logic               chan_err
);
    localparam int SW = DATA_W + FRAC_W;
    localparam int PW = SW + COEFF_W + 2;
    localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(N_CHAN - 1);
    localparam logic [CHAN_W:0]   NCH     = (CHAN_W + 1)'(N_CHAN);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_CALC, S_OUT} state_t;
    state_t state, state_nx;

    logic [CHAN_W-1:0]        clr_cnt;
    logic                     clr_pend;
    logic                     in_xfer;
    logic                     in_range_c;
    logic signed [DATA_W-1:0] x_p0;
    logic [CHAN_W-1:0]        num_p0;
    logic [COEFF_W-1:0]       coeff_p0;
    logic                     bypass_p0;
    logic                     in_range_p0;
    logic signed [SW-1:0]     lp_p1;
    logic signed [SW:0]       xe_c, d_c;
    logic signed [PW-1:0]     d_x, c_x, prod_c;
    logic signed [SW-1:0]     step_c, lp_nx;
    logic signed [DATA_W-1:0] y_c;
    logic signed [SW-1:0]     mem [N_CHAN];

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [SW:0] d);
        logic signed [DATA_W:0] q;
        q = (DATA_W + 1)'(d >>> FRAC_W);
        if (q[DATA_W] != q[DATA_W-1])
            return q[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return q[DATA_W-1:0];
    endfunction

    assign in_range_c = ({1'b0, chan_in_num} < NCH);
    assign in_xfer    = chan_in_valid & chan_in_read;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_CLEAR;
            clr_cnt         <= '0;
            clr_pend        <= 1'b0;
            chan_out_valid  <= 1'b0;
            chan_out_sample <= '0;
            chan_out_num    <= '0;
            chan_err        <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR)
                clr_cnt <= (clr_cnt == LAST_CH) ? '0 : clr_cnt + CHAN_W'(1);
            else
                clr_cnt <= '0;
            if (state == S_IDLE && state_nx == S_CLEAR)
                clr_pend <= 1'b0;
            else if (clear_state)
                clr_pend <= 1'b1;
            if (in_xfer && !in_range_c)
                chan_err <= 1'b1;
            if (state == S_CALC) begin
                chan_out_valid  <= 1'b1;
                chan_out_sample <= y_c;
                chan_out_num    <= num_p0;
            end else if (state == S_OUT && chan_out_read) begin
                chan_out_valid <= 1'b0;
            end
        end
    end

    // p0: sample captured at input transfer
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            x_p0        <= chan_in_sample;
            num_p0      <= chan_in_num;
            coeff_p0    <= coeff;
            bypass_p0   <= bypass;
            in_range_p0 <= in_range_c;
        end
    end

    // p1: channel state read; out-of-range channels never touch the RAM
    always_ff @(posedge clk) begin
        if (state == S_RD)
            lp_p1 <= in_range_p0 ? mem[num_p0] : '0;
    end

    always_comb begin
        xe_c   = {x_p0[DATA_W-1], x_p0, {FRAC_W{1'b0}}};
        d_c    = xe_c - {lp_p1[SW-1], lp_p1};
        d_x    = PW'(d_c);
        c_x    = PW'($signed({1'b0, coeff_p0}));
        prod_c = d_x * c_x;
        // step may exceed SW bits, but lp + step always fits, so wrap-around is exact
        step_c = SW'(prod_c >>> COEFF_W);
        lp_nx  = lp_p1 + step_c;
        y_c    = (bypass_p0 || !in_range_p0) ? x_p0 : sat_out(d_c);
    end

    // p2: state write-back on entry to OUT, or zero sweep during CLEAR
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[clr_cnt] <= '0;
        else if (reset && state == S_CALC && in_range_p0)
            mem[num_p0] <= lp_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR: if (clr_cnt == LAST_CH) state_nx = S_IDLE;
            S_IDLE: begin
                if (clr_pend || clear_state) state_nx = S_CLEAR;
                else if (chan_in_valid)      state_nx = S_RD;
            end
            S_RD:    state_nx = S_CALC;
            S_CALC:  state_nx = S_OUT;
            S_OUT:   if (chan_out_read) state_nx = S_IDLE;
            default: state_nx = S_CLEAR;
        endcase
    end

    // A pending clear holds off new input so no accepted sample is ever dropped.
    always_comb begin
        chan_in_read = (state == S_IDLE) && !clr_pend && !clear_state;
    end
endmodule

// File: tb/tb_cust_hp_filter_mc.sv
// Directed-vector bench for cust_hp_filter_mc; a monitor checks every output
// transfer against a queue of hand-computed expected samples.
module tb_cust_hp_filter_mc;
    localparam int DATA_W  = 16;
    localparam int CHAN_W  = 8;
    localparam int N_CHAN  = 160;
    localparam int COEFF_W = 16;
    localparam int FRAC_W  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [DATA_W-1:0]  chan_in_sample;
    logic [CHAN_W-1:0]  chan_in_num;
    logic               chan_in_valid;
    logic               chan_in_read;
    logic [DATA_W-1:0]  chan_out_sample;
    logic [CHAN_W-1:0]  chan_out_num;
    logic               chan_out_valid;
    logic               chan_out_read;
    logic [COEFF_W-1:0] coeff;
    logic               bypass;
    logic               clear_state;
    logic               chan_err;

    cust_hp_filter_mc #(
        .DATA_W(DATA_W), .CHAN_W(CHAN_W), .N_CHAN(N_CHAN),
        .COEFF_W(COEFF_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
        .chan_in_valid(chan_in_valid), .chan_in_read(chan_in_read),
        .chan_out_sample(chan_out_sample), .chan_out_num(chan_out_num),
        .chan_out_valid(chan_out_valid), .chan_out_read(chan_out_read),
        .coeff(coeff), .bypass(bypass), .clear_state(clear_state),
        .chan_err(chan_err)
    );

    always #5 clk = ~clk;

    logic [CHAN_W+DATA_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_sent  = 0;

    // Scoreboard monitor: every output transfer pops one expected entry.
    always @(negedge clk) begin
        logic [CHAN_W+DATA_W-1:0] e;
        if (reset === 1'b1 && chan_out_valid && chan_out_read) begin
            n_out++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected got num=%0d sample=%0d required no output",
                         chan_out_num, $signed(chan_out_sample));
            end else begin
                e = exp_q.pop_front();
                if ({chan_out_num, chan_out_sample} !== e) begin
                    n_fail++;
                    $display("FAIL out_sample got num=%0d sample=%0d required num=%0d sample=%0d",
                             chan_out_num, $signed(chan_out_sample),
                             e[CHAN_W+DATA_W-1:DATA_W], $signed(e[DATA_W-1:0]));
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic send(input int num, input int x, input int cf, input bit byp, input int ex);
        int t;
        chan_in_num    = num[CHAN_W-1:0];
        chan_in_sample = x[DATA_W-1:0];
        coeff          = cf[COEFF_W-1:0];
        bypass         = byp;
        chan_in_valid  = 1'b1;
        exp_q.push_back({num[CHAN_W-1:0], ex[DATA_W-1:0]});
        n_sent++;
        t = 0;
        while (!chan_in_read && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!chan_in_read) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout got read=0 required read=1 within 500 cycles");
        end
        @(posedge clk);
        #1 chan_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout got %0d pending outputs required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_state = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, n0;
        int exp5 [5] = '{1000, 500, 250, 125, 62};
        reset          = 1'b0;
        chan_in_sample = '0;
        chan_in_num    = '0;
        chan_in_valid  = 1'b0;
        chan_out_read  = 1'b1;
        coeff          = '0;
        bypass         = 1'b0;
        clear_state    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_read",    chan_in_read,    0);
        check("rst_out_valid",  chan_out_valid,  0);
        check("rst_out_sample", chan_out_sample, 0);
        check("rst_out_num",    chan_out_num,    0);
        check("rst_chan_err",   chan_err,        0);

        // Clear sweep after reset release
        reset = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!chan_in_read && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_sweep_len", cnt, N_CHAN);

        // Single channel decay with a = 0.5
        for (int i = 0; i < 5; i++) send(5, 1000, 32768, 1'b0, exp5[i]);
        drain();

        // Interleaved channels stay independent
        send(0, 1000, 32768, 1'b0, 1000);
        send(1, -2000, 32768, 1'b0, -2000);
        send(0, 1000, 32768, 1'b0, 500);
        send(1, -2000, 32768, 1'b0, -1000);
        send(0, 1000, 32768, 1'b0, 250);
        send(1, -2000, 32768, 1'b0, -500);
        send(4, 1000, 32768, 1'b0, 1000);
        drain();

        // Output backpressure
        chan_out_read = 1'b0;
        send(2, 300, 32768, 1'b0, 300);
        cnt = 0;
        while (!chan_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {chan_out_valid, chan_in_read, chan_out_num, chan_out_sample},
                  {1'b1, 1'b0, 8'd2, 16'd300});
        end
        n0 = n_out;
        @(posedge clk);
        #1 chan_out_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_one_xfer", n_out - n0, 1);
        check("stall_valid_drop", chan_out_valid, 0);

        // Bypass passes input but still updates state
        send(3, 400, 32768, 1'b1, 400);
        send(3, 400, 32768, 1'b0, 200);
        drain();

        // Clear requested during CALC: in-flight sample completes, then sweep
        send(0, 1000, 32768, 1'b0, 125);
        @(posedge clk);
        #1 clear_state = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
        drain();
        cnt = 0;
        while (!chan_in_read && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("clear_calc_sweep", (cnt >= N_CHAN && cnt <= N_CHAN + 3) ? 1 : 0, 1);
        send(0, 1000, 32768, 1'b0, 1000);
        send(1, -2000, 32768, 1'b0, -2000);
        drain();

        // Saturation with a close to 1
        pulse_clear();
        send(0, 32767, 65535, 1'b0, 32767);
        for (int i = 0; i < 19; i++) send(0, 32767, 65535, 1'b0, 0);
        send(0, -32768, 65535, 1'b0, -32768);
        drain();

        // Out-of-range channel and sticky error
        check("err_before", chan_err, 0);
        send(200, -1234, 32768, 1'b0, -1234);
        drain();
        check("err_set", chan_err, 1);
        send(7, 100, 0, 1'b0, 100);
        send(7, 100, 0, 1'b0, 100);
        drain();
        check("err_sticky", chan_err, 1);

        check("all_outputs_seen", n_out, n_sent);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
